// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch controller: FSM state encoding,
// reset PC and the layout of the one-entry instruction buffer.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] PC_RESET = 64'h8000_0000;
  localparam logic [XLEN-1:0] PC_STEP  = 64'd4;

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_DROP,
    S_WAIT
  } fetch_ctrl_state_t;

  // One buffered instruction as presented to the fetch stage.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            misaligned;
  } fetch_buf_t;

  // Instructions are 4-byte aligned; any low-bit set means the PC cannot be fetched.
  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-bus interface between the fetch controller (master) and the
// memory side (slave). A request is held stable until the response strobe.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            iresp_data_ok;
  logic [ILEN-1:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_data_ok,
    output iresp_data
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, issues one instruction-bus request
// at a time, buffers the returned word until the downstream stage accepts it,
// and applies PC redirects, draining any request already on the bus.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   S_REQ  | request pc_q on the bus (or buffer a misaligned fault entry)
//   S_HOLD | buffered instruction presented, waiting for !stall
//   S_DROP | redirected mid-request: hold the old request, discard the reply
//   S_WAIT | parked after a misaligned fault until a redirect arrives
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = PC_RESET
) (
  input  logic              clk,
  input  logic              reset,
  fetch_ctrl_if.master      ibus,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              stall,
  output logic              instr_valid,
  output logic [XLEN-1:0]   instr_pc,
  output logic [ILEN-1:0]   raw_instr,
  output logic              misaligned
);

  fetch_ctrl_state_t state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
  fetch_buf_t        buf_q, buf_d;
  logic              buf_valid_q, buf_valid_d;
  logic              pc_mis;

  assign pc_mis = pc_misaligned(pc_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update; a redirect takes priority over stall and data_ok.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;

    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          // Nothing outstanding (misaligned) or the reply lands now: retarget at once.
          if (pc_mis || ibus.iresp_data_ok) begin
            pc_d = redirect_pc;
          end else begin
            pend_pc_d = redirect_pc;
            state_d   = S_DROP;
          end
        end else if (pc_mis) begin
          buf_d       = '{pc: pc_q, instr: '0, misaligned: 1'b1};
          buf_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else if (ibus.iresp_data_ok) begin
          buf_d       = '{pc: pc_q, instr: ibus.iresp_data, misaligned: 1'b0};
          buf_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          buf_valid_d = 1'b0;
          pc_d        = redirect_pc;
          state_d     = S_REQ;
        end else if (!stall) begin
          buf_valid_d = 1'b0;
          if (buf_q.misaligned) begin
            state_d = S_WAIT;
          end else begin
            pc_d    = pc_q + PC_STEP;
            state_d = S_REQ;
          end
        end
      end

      S_DROP: begin
        if (redirect_valid) begin
          if (ibus.iresp_data_ok) begin
            pc_d    = redirect_pc;
            state_d = S_REQ;
          end else begin
            pend_pc_d = redirect_pc;
          end
        end else if (ibus.iresp_data_ok) begin
          pc_d    = pend_pc_q;
          state_d = S_REQ;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Bus outputs; reset suppresses the request so the ibus sees the abort immediately.
  always_comb begin
    ibus.ireq_valid = 1'b0;
    ibus.ireq_addr  = pc_q;
    if (!reset) begin
      ibus.ireq_valid = ((state_q == S_REQ) && !pc_mis) || (state_q == S_DROP);
    end
  end

  // PC, pending redirect target and the presented-instruction buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      pend_pc_q   <= RESET_PC;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign instr_valid = buf_valid_q;
  assign instr_pc    = buf_q.pc;
  assign raw_instr   = buf_q.instr;
  assign misaligned  = buf_q.misaligned;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by a long
// randomized run compared cycle by cycle against a behavioural model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [63:0] instr_pc;
  logic [31:0] raw_instr;
  logic        misaligned;

  int checks   = 0;
  int failures = 0;

  fetch_ctrl_if ibus ();

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ibus           (ibus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr_pc       (instr_pc),
    .raw_instr      (raw_instr),
    .misaligned     (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: fetch address, held instruction, squash and park flags.
  logic [63:0] m_pc     = RST_PC;
  logic [63:0] m_target = '0;
  logic        m_squash = 1'b0;
  logic        m_parked = 1'b0;
  logic        m_have   = 1'b0;
  logic [63:0] m_ipc    = '0;
  logic [31:0] m_iraw   = '0;
  logic        m_imis   = 1'b0;

  function automatic logic exp_req(input logic r);
    return !r && !m_have && !m_parked && (m_squash || (m_pc[1:0] == 2'b00));
  endfunction

  task automatic model_step();
    logic ok;
    ok = ibus.iresp_data_ok;
    if (reset) begin
      m_pc = RST_PC; m_squash = 0; m_parked = 0; m_have = 0;
      m_ipc = '0; m_iraw = '0; m_imis = 0;
    end else if (redirect_valid) begin
      if (m_have || m_parked) begin
        m_have = 0; m_parked = 0; m_pc = redirect_pc;
      end else if (m_squash) begin
        if (ok) begin m_squash = 0; m_pc = redirect_pc; end
        else m_target = redirect_pc;
      end else if (m_pc[1:0] != 2'b00 || ok) begin
        m_pc = redirect_pc;
      end else begin
        m_squash = 1; m_target = redirect_pc;
      end
    end else if (m_have) begin
      if (!stall) begin
        m_have = 0;
        if (m_imis) m_parked = 1;
        else m_pc = m_pc + 64'd4;
      end
    end else if (m_parked) begin
      m_parked = 1;
    end else if (m_squash) begin
      if (ok) begin m_squash = 0; m_pc = m_target; end
    end else if (m_pc[1:0] != 2'b00) begin
      m_have = 1; m_ipc = m_pc; m_iraw = '0; m_imis = 1;
    end else if (ok) begin
      m_have = 1; m_ipc = m_pc; m_iraw = ibus.iresp_data; m_imis = 0;
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [63:0] rpc,
                       input logic st, input logic ok, input logic [31:0] d);
    reset = r; redirect_valid = rv; redirect_pc = rpc; stall = st;
    ibus.iresp_data_ok = ok; ibus.iresp_data = d;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, '0);
  endtask

  task automatic clock();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, '0, 0, 0, '0);
    clock(); clock();
    checks++; if (ibus.ireq_valid !== 1'b0) begin failures++; $display("FAIL reset_ireq_valid: got %b want 0", ibus.ireq_valid); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL reset_misaligned: got %b want 0", misaligned); end
    checks++; if (raw_instr !== 32'd0) begin failures++; $display("FAIL reset_raw_instr: got %h want 0", raw_instr); end
    checks++; if (instr_pc !== 64'd0) begin failures++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    idle();
    checks++; if (ibus.ireq_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid: got %b want 1", ibus.ireq_valid); end
    checks++; if (ibus.ireq_addr !== RST_PC) begin failures++; $display("FAIL first_req_addr: got %h want %h", ibus.ireq_addr, RST_PC); end
  endtask

  task automatic test_basic();
    clock();
    idle();
    checks++; if (ibus.ireq_addr !== RST_PC || ibus.ireq_valid !== 1'b1) begin failures++; $display("FAIL basic_req_hold: got %b/%h want 1/%h", ibus.ireq_valid, ibus.ireq_addr, RST_PC); end
    clock();
    drive(0, 0, '0, 0, 1, 32'h0000_0013);
    clock();
    idle();
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL basic_instr_valid: got %b want 1", instr_valid); end
    checks++; if (instr_pc !== RST_PC) begin failures++; $display("FAIL basic_instr_pc: got %h want %h", instr_pc, RST_PC); end
    checks++; if (raw_instr !== 32'h0000_0013) begin failures++; $display("FAIL basic_raw_instr: got %h want 00000013", raw_instr); end
    checks++; if (ibus.ireq_valid !== 1'b0) begin failures++; $display("FAIL basic_no_req_in_hold: got %b want 0", ibus.ireq_valid); end
    clock();
    checks++; if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== 64'h8000_0004) begin failures++; $display("FAIL basic_next_req: got %b/%h want 1/80000004", ibus.ireq_valid, ibus.ireq_addr); end
  endtask

  task automatic test_stall();
    logic [31:0] d0;
    d0 = $urandom;
    drive(0, 0, '0, 0, 1, d0);
    clock();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, '0, 1, 0, '0);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 64'h8000_0004 || raw_instr !== d0 || ibus.ireq_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h raw=%h req=%b want v=1 pc=80000004 raw=%h req=0", i, instr_valid, instr_pc, raw_instr, ibus.ireq_valid, d0);
      end
      clock();
    end
    idle();
    clock();
    checks++; if (instr_valid !== 1'b0 || ibus.ireq_addr !== 64'h8000_0008 || ibus.ireq_valid !== 1'b1) begin failures++; $display("FAIL stall_release: got v=%b req=%b addr=%h want v=0 req=1 addr=80000008", instr_valid, ibus.ireq_valid, ibus.ireq_addr); end
    clock();
    checks++; if (ibus.ireq_addr !== 64'h8000_0008) begin failures++; $display("FAIL stall_single_advance: got %h want 80000008", ibus.ireq_addr); end
  endtask

  task automatic test_redirect_inflight();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, '0, 0, 1, $urandom);
      clock();
      idle();
      clock();
    end
    checks++; if (ibus.ireq_addr !== 64'h8000_0010 || ibus.ireq_valid !== 1'b1) begin failures++; $display("FAIL inflight_setup: got %b/%h want 1/80000010", ibus.ireq_valid, ibus.ireq_addr); end
    clock();
    drive(0, 1, 64'h8000_0100, 0, 0, '0);
    clock();
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== 64'h8000_0010 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL inflight_hold[%0d]: got req=%b addr=%h v=%b want req=1 addr=80000010 v=0", i, ibus.ireq_valid, ibus.ireq_addr, instr_valid);
      end
      clock();
    end
    drive(0, 0, '0, 0, 1, 32'hDEAD_BEEF);
    clock();
    idle();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL inflight_word_dropped: got v=%b want 0", instr_valid); end
    checks++; if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== 64'h8000_0100) begin failures++; $display("FAIL inflight_next_req: got %b/%h want 1/80000100", ibus.ireq_valid, ibus.ireq_addr); end
  endtask

  task automatic test_redirect_same_cycle();
    drive(0, 1, 64'h8000_0180, 0, 1, 32'h0BAD_0BAD);
    clock();
    idle();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL same_cycle_dropped: got v=%b want 0", instr_valid); end
    checks++; if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== 64'h8000_0180) begin failures++; $display("FAIL same_cycle_next_req: got %b/%h want 1/80000180", ibus.ireq_valid, ibus.ireq_addr); end
    clock();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL same_cycle_still_empty: got v=%b want 0", instr_valid); end
  endtask

  task automatic test_misaligned();
    drive(0, 0, '0, 0, 1, $urandom);
    clock();
    drive(0, 1, 64'h8000_0102, 0, 0, '0);
    clock();
    idle();
    checks++; if (instr_valid !== 1'b0 || ibus.ireq_valid !== 1'b0) begin failures++; $display("FAIL mis_squash: got v=%b req=%b want 0/0", instr_valid, ibus.ireq_valid); end
    clock();
    checks++;
    if (instr_valid !== 1'b1 || misaligned !== 1'b1 || raw_instr !== 32'd0 || instr_pc !== 64'h8000_0102 || ibus.ireq_valid !== 1'b0) begin
      failures++;
      $display("FAIL mis_entry: got v=%b mis=%b raw=%h pc=%h req=%b want 1/1/0/80000102/0", instr_valid, misaligned, raw_instr, instr_pc, ibus.ireq_valid);
    end
    clock();
    for (int i = 0; i < 4; i++) begin
      idle();
      checks++; if (instr_valid !== 1'b0 || ibus.ireq_valid !== 1'b0) begin failures++; $display("FAIL mis_park[%0d]: got v=%b req=%b want 0/0", i, instr_valid, ibus.ireq_valid); end
      clock();
    end
    drive(0, 1, 64'h8000_0200, 0, 0, '0);
    clock();
    idle();
    checks++; if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== 64'h8000_0200) begin failures++; $display("FAIL mis_resume: got %b/%h want 1/80000200", ibus.ireq_valid, ibus.ireq_addr); end
  endtask

  task automatic test_reset_midflight();
    clock();
    drive(1, 0, '0, 0, 0, '0);
    clock();
    checks++; if (ibus.ireq_valid !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL midreset_abort: got req=%b v=%b want 0/0", ibus.ireq_valid, instr_valid); end
    idle();
    checks++; if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== RST_PC) begin failures++; $display("FAIL midreset_restart: got %b/%h want 1/%h", ibus.ireq_valid, ibus.ireq_addr, RST_PC); end
  endtask

  task automatic test_wrap();
    drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, '0);
    clock();
    drive(0, 0, '0, 0, 1, $urandom);
    clock();
    idle();
    checks++; if (ibus.ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_target: got %h want fffffffffffffffc", ibus.ireq_addr); end
    drive(0, 0, '0, 0, 1, $urandom);
    clock();
    idle();
    clock();
    checks++; if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== 64'd0) begin failures++; $display("FAIL wrap_zero: got %b/%h want 1/0", ibus.ireq_valid, ibus.ireq_addr); end
  endtask

  task automatic test_random();
    int age;
    int lat;
    logic r, rv, st, ok, er;
    logic [63:0] rpc;
    age = 0;
    lat = $urandom_range(0, 3);
    for (int c = 0; c < 4000; c++) begin
      r  = ($urandom_range(0, 199) == 0);
      rv = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0:       rpc = 64'hFFFF_FFFF_FFFF_FFFC;
        1:       rpc = {$urandom, $urandom};
        default: rpc = {$urandom, $urandom} & ~64'd3;
      endcase
      er = exp_req(r);
      ok = er && (age >= lat);
      drive(r, rv, rpc, st, ok, $urandom);
      checks++; if (ibus.ireq_valid !== er) begin failures++; $display("FAIL rand_req_valid @%0d: got %b want %b", c, ibus.ireq_valid, er); end
      if (er) begin
        checks++; if (ibus.ireq_addr !== m_pc) begin failures++; $display("FAIL rand_req_addr @%0d: got %h want %h", c, ibus.ireq_addr, m_pc); end
      end
      clock();
      if (er && !ok && !r) age++;
      else begin age = 0; lat = $urandom_range(0, 3); end
      checks++; if (instr_valid !== m_have) begin failures++; $display("FAIL rand_instr_valid @%0d: got %b want %b", c, instr_valid, m_have); end
      if (m_have) begin
        checks++;
        if (instr_pc !== m_ipc || raw_instr !== m_iraw || misaligned !== m_imis) begin
          failures++;
          $display("FAIL rand_instr @%0d: got pc=%h raw=%h mis=%b want pc=%h raw=%h mis=%b", c, instr_pc, raw_instr, misaligned, m_ipc, m_iraw, m_imis);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_misaligned();
    test_reset_midflight();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
